// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, byte FIFO,
// and a start/data/stop serialiser driving a registered tx line.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       hit_data, hit_stat, push_req, push_ok, pop;
  logic       full, empty, busy, baud_end;
  logic [7:0] head;
  logic       unused_bits;

  assign hit_data = (address[31:2] == BASE_ADDR[31:2]);
  assign hit_stat = (address[31:2] == STAT_ADDR[31:2]);
  assign sel      = hit_data | hit_stat;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE);
  assign baud_end = (baud_q == BAUD_LAST);
  assign head     = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the serialiser pops in the same cycle.
  assign push_req = we & hit_data;
  assign push_ok  = push_req & (~full | pop);

  assign unused_bits = ^{wdata[31:8], address[1:0]};

  always_comb begin
    rdata = '0;
    if (hit_stat) begin
      rdata = {16'b0, 8'(count_q), 4'b0, overflow_q, busy, empty, full};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push_ok) count_q <= count_q - CW'(1);
      if (we && hit_stat)              overflow_q <= 1'b0;
      else if (push_req && !push_ok)   overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && resetn) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // tx_d is the line level for the state being entered, so tx stays a pure flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue/timestamp model of the FIFO and line predicts
// tx and STATUS; scenario tasks compare the DUT against it and against fixed values.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] STAT  = 32'h8000_0004;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        we = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .address(address), .wdata(wdata), .we(we),
    .rdata(rdata), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;

  // Model: a byte queue; a frame occupies the line for FRAME cycles from its pop edge.
  int         cyc = 0;
  int         last_pop = -1000;
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  bit         m_ovf = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      q.delete();
      m_ovf    = 1'b0;
      last_pop = -1000;
    end else begin
      if (q.size() > 0 && cyc >= last_pop + FRAME) begin
        cur      = q.pop_front();
        last_pop = cyc;
      end
      if (we && address[31:2] == BASE[31:2]) begin
        if (q.size() < DEPTH) q.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end
      if (we && address[31:2] == STAT[31:2]) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_busy();
    return (cyc - last_pop) < FRAME;
  endfunction

  function automatic logic exp_tx();
    int k;
    k = cyc - last_pop;
    if (k >= FRAME) return 1'b1;
    if (k < CPB) return 1'b0;
    if (k < 9 * CPB) return cur[(k - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(q.size()), 4'h0, m_ovf, exp_busy(), q.size() == 0, q.size() == DEPTH};
  endfunction

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; address = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", sel); end
    address = STAT; #1;
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp 00000002", rdata); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel_stat got %b exp 1", sel); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    step(1'b1, BASE, 32'h55);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_pre_tx got %b exp 1", tx); end
    for (int i = 1; i <= 44; i++) begin
      step(1'b0, STAT, 32'h0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL single_tx i=%0d got %b exp %b", i, tx, exp_tx()); end
      if (i == 1 || i == 4 || i == 9) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_low i=%0d got %b exp 0", i, tx); end
      end
      if (i == 5 || i == 13 || i == 37 || i == 40) begin
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_high i=%0d got %b exp 1", i, tx); end
      end
      if (i == 20 || i == 40) begin
        checks++; if (rdata[2] !== 1'b1) begin errors++; $display("FAIL single_busy i=%0d got %b exp 1", i, rdata[2]); end
      end
      if (i == 41) begin
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL single_done got %h exp 00000002", rdata); end
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    for (int i = 1; i <= 6; i++) step(1'b1, BASE, i);
    we = 1'b0; address = STAT; #1;
    checks++; if (rdata !== 32'h40D) begin errors++; $display("FAIL ovf_status got %h exp 0000040d", rdata); end
    step(1'b1, STAT, $urandom);
    checks++; if (rdata !== 32'h405) begin errors++; $display("FAIL ovf_clear got %h exp 00000405", rdata); end
    while (cyc + 1 < last_pop + FRAME) begin
      step(1'b0, STAT, 32'h0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
    step(1'b1, BASE, 32'hA7);
    we = 1'b0; address = STAT; #1;
    checks++; if (rdata !== 32'h405) begin errors++; $display("FAIL ovf_pushpop got %h exp 00000405", rdata); end
    n = 0;
    while (n < 400 && (q.size() > 0 || exp_busy())) begin
      step(1'b0, STAT, 32'h0);
      n++;
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_drain_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL ovf_drained got %h exp 00000002", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic       s[45];
    int         n;
    b0 = 8'($urandom); b1 = 8'($urandom);
    step(1'b1, BASE, {24'h0, b0});
    step(1'b1, BASE, {24'h0, b1});
    s[0] = tx;
    for (int j = 1; j <= 44; j++) begin
      step(1'b0, STAT, 32'h0);
      s[j] = tx;
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_tx j=%0d got %b exp %b", j, tx, exp_tx()); end
    end
    checks++; if (s[0] !== 1'b0) begin errors++; $display("FAIL b2b_start0 got %b exp 0", s[0]); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (s[4 + 4 * k] !== b0[k]) begin errors++; $display("FAIL b2b_bit%0d got %b exp %b", k, s[4 + 4 * k], b0[k]); end
    end
    for (int j = 36; j <= 39; j++) begin
      checks++; if (s[j] !== 1'b1) begin errors++; $display("FAIL b2b_stop j=%0d got %b exp 1", j, s[j]); end
    end
    checks++; if (s[40] !== 1'b0) begin errors++; $display("FAIL b2b_start1 got %b exp 0", s[40]); end
    checks++; if (s[44] !== b1[0]) begin errors++; $display("FAIL b2b_b1bit0 got %b exp %b", s[44], b1[0]); end
    n = 0;
    while (n < 400 && (q.size() > 0 || exp_busy())) begin
      step(1'b0, STAT, 32'h0);
      n++;
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_drain_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL b2b_drained got %h exp 00000002", rdata); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, BASE, 32'h3C);
    step(1'b1, BASE, 32'hC3);
    step(1'b1, BASE, 32'h0F);
    for (int j = 0; j < 12; j++) step(1'b0, STAT, 32'h0);
    resetn = 1'b0;
    step(1'b1, BASE, 32'hAA);
    resetn = 1'b1;
    we = 1'b0; address = STAT; #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", tx); end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL rstmid_status got %h exp 00000002", rdata); end
    for (int j = 0; j < 60; j++) begin
      step(1'b0, STAT, 32'h0);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_quiet j=%0d got %b exp 1", j, tx); end
    end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL rstmid_after got %h exp 00000002", rdata); end
  endtask

  task automatic test_random();
    int          r;
    logic [31:0] a;
    logic        w;
    logic        hit;
    for (int n = 0; n < 1500; n++) begin
      we = 1'b0; address = STAT; #1;
      checks++; if (rdata !== exp_status()) begin errors++; $display("FAIL rnd_status cyc=%0d got %h exp %h", cyc, rdata, exp_status()); end
      r = $urandom_range(0, 9);
      if (r < 4)      a = BASE | 32'($urandom_range(0, 3));
      else if (r < 6) a = STAT | 32'($urandom_range(0, 3));
      else if (r < 7) a = BASE + 32'd8;
      else if (r < 8) a = BASE - 32'd4;
      else            a = $urandom;
      w = ($urandom_range(0, 3) == 0);
      hit = (a[31:2] == BASE[31:2]) || (a[31:2] == STAT[31:2]);
      we = w; address = a; #1;
      checks++; if (sel !== hit) begin errors++; $display("FAIL rnd_sel addr=%h got %b exp %b", a, sel, hit); end
      if (a[31:2] != STAT[31:2]) begin
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rnd_rdata addr=%h got %h exp 0", a, rdata); end
      end
      step(w, a, $urandom);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL rnd_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
